// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: func3 width encodings, FSM states
// and store lane helpers. Also used by execute.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Undefined func3 encodings fall back to a word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            F3_W:        f3_size = SZ_W;
            default:     f3_size = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_B:    store_strb = 4'b0001 << off;
            SZ_H:    store_strb = off[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] sd);
        case (sz)
            SZ_B:    store_wdata = {4{sd[7:0]}};
            SZ_H:    store_wdata = {2{sd[15:0]}};
            default: store_wdata = sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane selection: picks the addressed byte/half out of the read word and
// sign- or zero-extends it according to func3.
module load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        func3,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic              uns;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        uns     = func3[2];
        case (f3_size(func3))
            SZ_B:    data = uns ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            SZ_H:    data = uns ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: byte/half/word loads and stores over a req/ack port, registered writeback.
// Optional MEM_MISALIGN_TRAP_EN adds a misaligned-access trap pulse instead of a memory request.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        dest_i,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic              wb_en,
    output logic [4:0]        wb_dest,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    state_t            state, state_nxt;
    size_t             size_in;
    logic              accept, is_mem, is_st, trap;
    logic [1:0]        off_eff;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic [4:0]        dest_q;
    logic              load_q;
    logic [DATA_W-1:0] load_word;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign is_mem   = is_load || is_store;
    assign is_st    = is_store && !is_load;   // load wins when both flags are set
    assign size_in  = f3_size(func3);

    always_comb begin
        case (size_in)
            SZ_B:    off_eff = addr[1:0];
            SZ_H:    off_eff = {addr[1], 1'b0};
            default: off_eff = 2'b00;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && (((size_in == SZ_H) && addr[0]) ||
                             ((size_in == SZ_W) && (addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem && !trap) state_nxt = WAIT;
            WAIT:    if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .func3  (func3_q),
        .data   (load_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            out_valid  <= 1'b0;
            wb_en      <= 1'b0;
            wb_dest    <= '0;
            wb_data    <= '0;
            func3_q    <= '0;
            off_q      <= '0;
            dest_q     <= '0;
            load_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            out_valid  <= 1'b0;
            wb_en      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            if (state == IDLE) begin
                if (accept && trap) begin
                    out_valid  <= 1'b1;
                    wb_dest    <= '0;
                    wb_data    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                    misaligned <= 1'b1;
`endif
                end else if (accept && is_mem) begin
                    mem_req   <= 1'b1;
                    mem_we    <= is_st;
                    mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb <= is_st ? store_strb(size_in, off_eff) : 4'b0000;
                    mem_wdata <= store_wdata(size_in, store_data);
                    func3_q   <= func3;
                    off_q     <= off_eff;
                    dest_q    <= dest_i;
                    load_q    <= !is_st;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    wb_en     <= (dest_i != 5'd0);
                    wb_dest   <= dest_i;
                    wb_data   <= addr;
                end
            end else if (mem_ack) begin
                // Ack cycle: drop the request and present writeback next cycle.
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_wstrb <= 4'b0000;
                out_valid <= 1'b1;
                wb_en     <= load_q && (dest_q != 5'd0);
                wb_dest   <= load_q ? dest_q : 5'd0;
                wb_data   <= load_q ? load_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: byte-level memory reference model, randomized
// loads/stores/ALU ops, req/ack responder with random latency. MEM_MISALIGN_TRAP_EN aware.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, is_load, is_store;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic [4:0]  dest_i;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        out_valid, wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    mem_access dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .is_load    (is_load),
        .is_store   (is_store),
        .func3      (func3),
        .addr       (addr),
        .store_data (store_data),
        .dest_i     (dest_i),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .out_valid  (out_valid),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misaligned (misaligned)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        en;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        mis;
    } wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    int          delay_q[$];
    logic [7:0]  ref_mem[0:1023];
    logic [31:0] resp_mem[0:255];
    int          n_vec = 0;
    int          n_err = 0;
    bit          late_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        resp_mem[a[9:2]] = w;
        for (int k = 0; k < 4; k++) ref_mem[{a[9:2], 2'b00} + k] = w[8*k +: 8];
    endtask

    // Reference: effective byte address, byte-wise little-endian memory, extension by func3.
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] d, input int dly, input bit abandon = 1'b0);
        int          size, guard;
        bit          uns, mem, isst, mis;
        logic [31:0] ea, val, mask;
        wb_t         w;
        req_t        r;
        if (f3 == 3'b000 || f3 == 3'b100)      size = 1;
        else if (f3 == 3'b001 || f3 == 3'b101) size = 2;
        else                                   size = 4;
        uns  = (f3 == 3'b100 || f3 == 3'b101);
        mem  = ld || st;
        isst = st && !ld;
        ea   = a & ~(32'(size) - 32'd1);
        mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = mem && (ea != a);
`endif
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; is_load = ld; is_store = st; func3 = f3;
        addr = a; store_data = sd; dest_i = d;
        w.en = 1'b0; w.dest = 5'd0; w.data = 32'd0; w.mis = 1'b0;
        if (!mem) begin
            w.en = (d != 5'd0); w.dest = d; w.data = a;
            wb_q.push_back(w);
        end else if (mis) begin
            w.mis = 1'b1;
            wb_q.push_back(w);
        end else begin
            r.we = isst; r.addr = a & ~32'd3; r.strb = 4'd0; r.wdata = 32'd0;
            if (isst) begin
                r.strb = 4'(((1 << size) - 1) << ea[1:0]);
                r.wdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
                for (int k = 0; k < size; k++) ref_mem[(ea + k) % 1024] = sd[8*k +: 8];
            end else begin
                val = 32'd0;
                for (int k = 0; k < size; k++) val[8*k +: 8] = ref_mem[(ea + k) % 1024];
                if (size < 4) begin
                    mask = (32'd1 << (8 * size)) - 32'd1;
                    if (!uns && val[8*size-1]) val = val | ~mask;
                end
                w.en = (d != 5'd0); w.dest = d; w.data = val;
            end
            req_q.push_back(r);
            delay_q.push_back(dly);
            if (!abandon) wb_q.push_back(w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        is_load = 1'($urandom); is_store = 1'($urandom); func3 = 3'($urandom);
        addr = $urandom; store_data = $urandom; dest_i = 5'($urandom);
    endtask

    // Memory responder and request checker.
    initial begin : responder
        req_t e, seen;
        int   dly;
        bit   gone;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                seen.we = mem_we; seen.addr = mem_addr; seen.strb = mem_wstrb; seen.wdata = mem_wdata;
                if (req_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_mem_req: got addr %h, want no request", mem_addr);
                    e = seen; dly = 0;
                end else begin
                    e = req_q.pop_front();
                    dly = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
                end
                chk("mem_we", 32'(seen.we), 32'(e.we));
                chk("mem_addr", seen.addr, e.addr);
                chk("mem_wstrb", 32'(seen.strb), 32'(e.strb));
                if (e.we) chk("mem_wdata", seen.wdata, e.wdata);
                gone = 1'b0;
                for (int k = 0; k < dly && !gone; k++) begin
                    @(negedge clk);
                    if (mem_req !== 1'b1) gone = 1'b1;
                end
                if (!gone) begin
                    chk("req_stable_addr", mem_addr, seen.addr);
                    chk("req_stable_strb", 32'(mem_wstrb), 32'(seen.strb));
                    mem_rdata = resp_mem[mem_addr[9:2]];
                    if (mem_we === 1'b1)
                        for (int k = 0; k < 4; k++)
                            if (mem_wstrb[k]) resp_mem[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    chk("req_drop_after_ack", 32'(mem_req), 32'd0);
                end else if (late_ack) begin
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    late_ack = 1'b0;
                end
            end
        end
    end

    // Writeback monitor.
    initial begin : wb_monitor
        wb_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (wb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_out_valid: got wb_data %h, want no writeback", wb_data);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_en", 32'(wb_en), 32'(e.en));
`ifdef MEM_MISALIGN_TRAP_EN
                    chk("misaligned", 32'(misaligned), 32'(e.mis));
`endif
                    if (!e.mis) begin
                        chk("wb_dest", 32'(wb_dest), 32'(e.dest));
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end else if (wb_en === 1'b1) begin
                chk("wb_en_without_valid", 32'(wb_en), 32'd0);
            end
        end
    end

    initial begin : stimulus
        int          kind, guard;
        bit          ld, st;
        logic [2:0]  f3;
        logic [2:0]  f3_tab[8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
        for (int i = 0; i < 256; i++) preload(32'(i * 4), 32'(i) * 32'h9E3779B1 + 32'h01234567);
        reset = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        func3 = 3'd0; addr = 32'd0; store_data = 32'd0; dest_i = 5'd0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        preload(32'h100, 32'h80FF1234);
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd5, 2);           // lb
        issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 5'd7, 0);     // sh
        issue(1'b0, 1'b0, 3'b000, 32'hFFFFFF9C, 32'd0, 5'd9, 0);      // ALU pass-through
        preload(32'h40, 32'h80010000);
        issue(1'b1, 1'b0, 3'b101, 32'h42, 32'd0, 5'd12, 1);           // lhu
        issue(1'b1, 1'b0, 3'b101, 32'h42, 32'd0, 5'd0, 0);            // lhu to x0
        issue(1'b1, 1'b1, 3'b010, 32'h24, 32'h5555AAAA, 5'd3, 1);     // both flags: load

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 99);
            ld = (kind < 40) || (kind >= 95);
            st = (kind >= 40 && kind < 75) || (kind >= 95);
            f3 = f3_tab[$urandom_range(0, 7)];
            issue(ld, st, f3, 32'($urandom_range(0, 1023)), $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 3));
        end

        // Reset while waiting for ack abandons the load.
        issue(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 5'd3, 20, 1'b1);
        reset = 1'b1;
        late_ack = 1'b1;
        @(posedge clk); #1;
        chk("abandon_mem_req", 32'(mem_req), 32'd0);
        chk("abandon_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd6, 0);           // still works after abandon

`ifdef MEM_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 3'b010, 32'h5, 32'd0, 5'd4, 0);             // misaligned lw
        chk("trap_no_req", 32'(mem_req), 32'd0);
        issue(1'b0, 1'b1, 3'b001, 32'h23, 32'h1234, 5'd4, 0);         // misaligned sh
`endif

        guard = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        chk("drain_wb_queue", 32'(wb_q.size()), 32'd0);
        chk("drain_req_queue", 32'(req_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
